// File: rtl/hps_reset_req_pkg.sv
// Shared types and constants for the HPS reset request sequencer.
package hps_reset_req_pkg;

    localparam int unsigned NUM_KEYS = 4;
    localparam int unsigned STM_W    = 28;
    localparam int unsigned STATE_W  = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_MEASURE   = 3'd1;
    localparam state_t ST_ASSERT    = 3'd2;
    localparam state_t ST_WAIT_LOW  = 3'd3;
    localparam state_t ST_WAIT_HIGH = 3'd4;
    localparam state_t ST_COOLDOWN  = 3'd5;

    typedef enum logic [1:0] {
        KIND_WARM  = 2'd0,
        KIND_COLD  = 2'd1,
        KIND_DEBUG = 2'd2
    } kind_t;

    localparam int unsigned EV_WARM     = 0;
    localparam int unsigned EV_COLD     = 1;
    localparam int unsigned EV_DEBUG    = 2;
    localparam int unsigned EV_TIMEOUT  = 3;
    localparam int unsigned EV_ACK      = 4;
    localparam int unsigned EV_KEY_BASE = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hps_reset_req_ctrl_key_debounce.sv
// One KEY input: 2-flop synchronizer, stability counter and press-edge pulse.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_n_i,
    output logic stable_n_o,
    output logic press_edge_o
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             edge_q, edge_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bring the raw key into the clock domain; reset to "released".
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has differed from the stable one long enough.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        edge_d   = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            edge_d   = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stable_q <= 1'b1;
            cnt_q    <= '0;
            edge_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
        end
    end

    assign stable_n_o   = stable_q;
    assign press_edge_o = edge_q;

endmodule

// File: rtl/hps_reset_req_ctrl.sv
// Sequences HPS cold/warm/debug reset requests from the board KEY buttons.
module hps_reset_req_ctrl
    import hps_reset_req_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = 50_000,
    parameter int unsigned LONG_PRESS_CYCLES  = 150_000_000,
    parameter int unsigned REQ_HOLD_CYCLES    = 1024,
    parameter int unsigned ACK_TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned COOLDOWN_CYCLES    = 5_000_000
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_KEYS-1:0] button_n,
    input  logic [3:0]          dipsw,
    input  logic                h2f_reset_n,
    output logic                f2h_cold_req_n,
    output logic                f2h_warm_req_n,
    output logic                f2h_debug_req_n,
    output logic [STM_W-1:0]    stm_hwevents,
    output logic                busy
);
    localparam int unsigned CNT_MAX = max_u(max_u(LONG_PRESS_CYCLES, REQ_HOLD_CYCLES),
                                            max_u(ACK_TIMEOUT_CYCLES, COOLDOWN_CYCLES));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [NUM_KEYS-1:0] key_stable_n;
    logic [NUM_KEYS-1:0] press_edge;
    logic                arm_s1_q, arm_s2_q;
    logic                h2f_s1_q, h2f_s2_q;
    state_t              state_q, state_d;
    kind_t               kind_q, kind_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [STM_W-1:0]    ev_q, ev_d;
    logic                cold_n_q, warm_n_q, debug_n_q, busy_q;
    logic                unused_dipsw;

    assign unused_dipsw = ^dipsw[3:1];

    // Per-key debounce and press-edge detection.
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk_i       (clk_clk),
            .rst_n_i     (reset_reset_n),
            .key_n_i     (button_n[gi]),
            .stable_n_o  (key_stable_n[gi]),
            .press_edge_o(press_edge[gi])
        );
    end

    // Synchronize the arm switch and the HPS reset status.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            arm_s1_q <= 1'b0;
            arm_s2_q <= 1'b0;
            h2f_s1_q <= 1'b1;
            h2f_s2_q <= 1'b1;
        end else begin
            arm_s1_q <= dipsw[0];
            arm_s2_q <= arm_s1_q;
            h2f_s1_q <= h2f_reset_n;
            h2f_s2_q <= h2f_s1_q;
        end
    end

    // Next-state, shared counter and event pulses.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        ev_d    = '0;
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        ev_d[EV_KEY_BASE +: NUM_KEYS] = press_edge;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (arm_s2_q && h2f_s2_q) begin
                    if (press_edge[0]) begin
                        state_d = ST_MEASURE;
                    end else if (press_edge[1]) begin
                        state_d = ST_ASSERT;
                        kind_d  = KIND_DEBUG;
                    end
                end
            end
            ST_MEASURE: begin
                if (!arm_s2_q || !h2f_s2_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LONG_PRESS_CYCLES - 1)) begin
                    state_d = ST_ASSERT;
                    kind_d  = KIND_COLD;
                    cnt_d   = '0;
                end else if (key_stable_n[0]) begin
                    state_d = ST_ASSERT;
                    kind_d  = KIND_WARM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == CNT_W'(REQ_HOLD_CYCLES - 1)) begin
                    state_d = (kind_q == KIND_DEBUG) ? ST_COOLDOWN : ST_WAIT_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_LOW: begin
                if (!h2f_s2_q) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = cnt_inc;
                end else if (cnt_q >= CNT_W'(ACK_TIMEOUT_CYCLES - 1)) begin
                    state_d            = ST_COOLDOWN;
                    cnt_d              = '0;
                    ev_d[EV_TIMEOUT]   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_HIGH: begin
                if (h2f_s2_q) begin
                    state_d        = ST_COOLDOWN;
                    cnt_d          = '0;
                    ev_d[EV_ACK]   = 1'b1;
                end else if (cnt_q >= CNT_W'(ACK_TIMEOUT_CYCLES - 1)) begin
                    state_d            = ST_COOLDOWN;
                    cnt_d              = '0;
                    ev_d[EV_TIMEOUT]   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_COOLDOWN: begin
                if ((cnt_q >= CNT_W'(COOLDOWN_CYCLES - 1)) && (&key_stable_n)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if ((state_d == ST_ASSERT) && (state_q != ST_ASSERT)) begin
            case (kind_d)
                KIND_WARM:  ev_d[EV_WARM]  = 1'b1;
                KIND_COLD:  ev_d[EV_COLD]  = 1'b1;
                KIND_DEBUG: ev_d[EV_DEBUG] = 1'b1;
                default:    ;
            endcase
        end
    end

    // State and registered outputs, derived from the next state so requests start on entry.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q   <= ST_IDLE;
            kind_q    <= KIND_WARM;
            cnt_q     <= '0;
            ev_q      <= '0;
            cold_n_q  <= 1'b1;
            warm_n_q  <= 1'b1;
            debug_n_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            ev_q      <= ev_d;
            cold_n_q  <= ~((state_d == ST_ASSERT) && (kind_d == KIND_COLD));
            warm_n_q  <= ~((state_d == ST_ASSERT) && (kind_d == KIND_WARM));
            debug_n_q <= ~((state_d == ST_ASSERT) && (kind_d == KIND_DEBUG));
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign f2h_cold_req_n  = cold_n_q;
    assign f2h_warm_req_n  = warm_n_q;
    assign f2h_debug_req_n = debug_n_q;
    assign stm_hwevents    = ev_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_hps_reset_req_ctrl.sv
// Bench for hps_reset_req_ctrl: behavioural model compared every cycle, plus directed pins.
module tb_hps_reset_req_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 100;
    localparam int HOLD = 8;
    localparam int TO   = 50;
    localparam int COOL = 10;

    localparam int M_IDLE = 0, M_MEAS = 1, M_HOLD = 2, M_WLO = 3, M_WHI = 4, M_COOL = 5;

    logic        clk;
    logic        rst_n;
    logic [3:0]  button_n;
    logic [3:0]  dipsw;
    logic        h2f;
    logic        cold_n, warm_n, dbg_n, busy;
    logic [27:0] stm;

    hps_reset_req_ctrl #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG),
        .REQ_HOLD_CYCLES   (HOLD),
        .ACK_TIMEOUT_CYCLES(TO),
        .COOLDOWN_CYCLES   (COOL)
    ) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .button_n       (button_n),
        .dipsw          (dipsw),
        .h2f_reset_n    (h2f),
        .f2h_cold_req_n (cold_n),
        .f2h_warm_req_n (warm_n),
        .f2h_debug_req_n(dbg_n),
        .stm_hwevents   (stm),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;

    // ---------------- behavioural model ----------------
    logic [3:0]  m_b1, m_b2, m_st, m_pe;
    logic        m_a1, m_a2, m_h1, m_h2;
    int          m_run [4];
    int          m_mode, m_kind, m_held, m_hold_left, m_waited, m_cooled;
    logic [27:0] m_ev;
    logic [31:0] exp_vec;

    task automatic m_start(input int k);
        m_mode      = M_HOLD;
        m_kind      = k;
        m_hold_left = HOLD;
        m_ev[k]     = 1'b1;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_b1 = 4'hF; m_b2 = 4'hF; m_st = 4'hF; m_pe = 4'h0;
            m_a1 = 1'b0; m_a2 = 1'b0; m_h1 = 1'b1; m_h2 = 1'b1;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_mode = M_IDLE; m_kind = 0; m_held = 0; m_hold_left = 0;
            m_waited = 0; m_cooled = 0;
            m_ev = '0;
        end else begin
            m_ev = '0;
            m_ev[11:8] = m_pe;
            case (m_mode)
                M_IDLE: if (m_a2 && m_h2) begin
                    if (m_pe[0]) begin m_mode = M_MEAS; m_held = 0; end
                    else if (m_pe[1]) m_start(2);
                end
                M_MEAS: begin
                    if (!m_a2 || !m_h2) m_mode = M_IDLE;
                    else if (m_held == LONG - 1) m_start(1);
                    else if (m_st[0]) m_start(0);
                    else m_held++;
                end
                M_HOLD: begin
                    m_hold_left--;
                    if (m_hold_left == 0) begin
                        if (m_kind == 2) begin m_mode = M_COOL; m_cooled = 0; end
                        else begin m_mode = M_WLO; m_waited = 0; end
                    end
                end
                M_WLO: begin
                    if (!m_h2) begin m_mode = M_WHI; m_waited++; end
                    else if (m_waited >= TO - 1) begin m_ev[3] = 1'b1; m_mode = M_COOL; m_cooled = 0; end
                    else m_waited++;
                end
                M_WHI: begin
                    if (m_h2) begin m_ev[4] = 1'b1; m_mode = M_COOL; m_cooled = 0; end
                    else if (m_waited >= TO - 1) begin m_ev[3] = 1'b1; m_mode = M_COOL; m_cooled = 0; end
                    else m_waited++;
                end
                default: begin
                    if (m_cooled >= COOL - 1 && m_st == 4'hF) m_mode = M_IDLE;
                    else m_cooled++;
                end
            endcase
            for (int i = 0; i < 4; i++) begin
                m_pe[i] = 1'b0;
                if (m_b2[i] == m_st[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_st[i]  = m_b2[i];
                        m_run[i] = 0;
                        m_pe[i]  = ~m_b2[i];
                    end
                end
            end
            m_b2 = m_b1; m_b1 = button_n;
            m_a2 = m_a1; m_a1 = dipsw[0];
            m_h2 = m_h1; m_h1 = h2f;
        end
        exp_vec = {~(m_mode == M_HOLD && m_kind == 1), ~(m_mode == M_HOLD && m_kind == 0),
                   ~(m_mode == M_HOLD && m_kind == 2), (m_mode != M_IDLE), m_ev};
    end

    // ---------------- per-cycle compare and observation ----------------
    int cyc = 0;
    int obs_cold, obs_warm, obs_dbg, obs_busy;
    int obs_ev [28];
    int warm_rise_cyc, ev3_cyc;
    logic prev_warm = 1'b1;

    task automatic clear_obs();
        obs_cold = 0; obs_warm = 0; obs_dbg = 0; obs_busy = 0;
        for (int i = 0; i < 28; i++) obs_ev[i] = 0;
        warm_rise_cyc = -1; ev3_cyc = -1;
    endtask

    always @(negedge clk) begin
        logic [31:0] got;
        cyc++;
        got = {cold_n, warm_n, dbg_n, busy, stm};
        vectors++;
        if (got !== exp_vec) begin
            miscompares++;
            $display("FAIL cycle_cmp cyc=%0d got=%h exp=%h", cyc, got, exp_vec);
        end
        if (!cold_n) obs_cold++;
        if (!warm_n) obs_warm++;
        if (!dbg_n)  obs_dbg++;
        if (busy)    obs_busy++;
        for (int i = 0; i < 28; i++) if (stm[i]) obs_ev[i]++;
        if (!prev_warm && warm_n) warm_rise_cyc = cyc;
        if (stm[3]) ev3_cyc = cyc;
        prev_warm = warm_n;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic wait_req(input string name, input int bound);
        int n;
        n = 0;
        while ((cold_n & warm_n & dbg_n) && n < bound) begin tick(1); n++; end
        if (n >= bound) check({name, "_req_start_timeout"}, 0, 1);
        n = 0;
        while (!(cold_n & warm_n & dbg_n) && n < bound) begin tick(1); n++; end
        if (n >= bound) check({name, "_req_end_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin tick(1); n++; end
        if (n >= bound) check({name, "_idle_timeout"}, 0, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int kl [4];
        int hlo;
        rst_n = 1'b0; button_n = 4'hF; dipsw = 4'h0; h2f = 1'b1;
        clear_obs();
        tick(3);
        check("rst_reqs", int'({cold_n, warm_n, dbg_n}), 7);
        check("rst_stm", int'(stm), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        dipsw = 4'h1;
        tick(5);

        // 1: short KEY0 press -> warm, acknowledged by HPS
        clear_obs();
        button_n[0] = 1'b0; tick(20); button_n[0] = 1'b1;
        wait_req("s1", 200);
        h2f = 1'b0; tick(5); h2f = 1'b1;
        wait_idle("s1", 300);
        tick(2);
        check("s1_warm_len", obs_warm, HOLD);
        check("s1_ev_warm", obs_ev[0], 1);
        check("s1_ev_ack", obs_ev[4], 1);
        check("s1_ev_timeout", obs_ev[3], 0);
        check("s1_ev_key0", obs_ev[8], 1);
        check("s1_busy", int'(busy), 0);

        // 2: long KEY0 hold -> cold, cooldown waits for release
        clear_obs();
        button_n[0] = 1'b0;
        wait_req("s2", 400);
        h2f = 1'b0; tick(5); h2f = 1'b1;
        tick(40);
        check("s2_cool_hold", int'(busy), 1);
        button_n[0] = 1'b1;
        wait_idle("s2", 100);
        tick(2);
        check("s2_cold_len", obs_cold, HOLD);
        check("s2_warm_len", obs_warm, 0);
        check("s2_ev_cold", obs_ev[1], 1);

        // 3: KEY0 bouncing faster than the debounce window
        clear_obs();
        for (int i = 0; i < 15; i++) begin button_n[0] = ~button_n[0]; tick(2); end
        button_n[0] = 1'b1;
        tick(20);
        check("s3_ev_key0", obs_ev[8], 0);
        check("s3_busy", obs_busy, 0);
        check("s3_reqs", obs_cold + obs_warm + obs_dbg, 0);

        // 4: warm request never acknowledged -> timeout
        clear_obs();
        button_n[0] = 1'b0; tick(20); button_n[0] = 1'b1;
        wait_req("s4", 200);
        wait_idle("s4", 300);
        tick(2);
        check("s4_ev_timeout", obs_ev[3], 1);
        check("s4_ev_ack", obs_ev[4], 0);
        check("s4_timeout_lat", ev3_cyc - warm_rise_cyc, TO);
        check("s4_warm_len", obs_warm, HOLD);

        // 5: disarmed presses only produce key events; simultaneous presses take KEY0 path
        clear_obs();
        dipsw = 4'h0; tick(3);
        button_n[0] = 1'b0; tick(10); button_n[0] = 1'b1; tick(10);
        button_n[1] = 1'b0; tick(10); button_n[1] = 1'b1; tick(10);
        check("s5_ev_key0", obs_ev[8], 1);
        check("s5_ev_key1", obs_ev[9], 1);
        check("s5_busy", obs_busy, 0);
        dipsw = 4'h1; tick(3);
        clear_obs();
        button_n[1:0] = 2'b00; tick(20); button_n[1:0] = 2'b11;
        wait_req("s5", 200);
        wait_idle("s5", 300);
        tick(2);
        check("s5_debug_len", obs_dbg, 0);
        check("s5_warm_len", obs_warm, HOLD);
        check("s5_ev_debug", obs_ev[2], 0);

        // 6: reset in the middle of a debug request
        clear_obs();
        button_n[1] = 1'b0;
        begin
            int n;
            n = 0;
            while (dbg_n && n < 50) begin tick(1); n++; end
            if (n >= 50) check("s6_debug_start_timeout", 0, 1);
        end
        button_n[1] = 1'b1;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("s6_reqs", int'({cold_n, warm_n, dbg_n}), 7);
        check("s6_stm", int'(stm), 0);
        check("s6_busy", int'(busy), 0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("s6_idle", int'(busy), 0);

        // random traffic against the model
        for (int i = 0; i < 4; i++) kl[i] = 0;
        hlo = 0;
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (kl[i] == 0) begin
                    if ($urandom_range(0, 3) != 0) button_n[i] = ~button_n[i];
                    kl[i] = (i < 2) ? int'($urandom_range(1, 140)) : int'($urandom_range(1, 40));
                end else kl[i]--;
            end
            if ($urandom_range(0, 299) == 0) dipsw[0] = ~dipsw[0];
            if (hlo > 0) begin hlo--; h2f = (hlo == 0); end
            else if ($urandom_range(0, 79) == 0) begin hlo = int'($urandom_range(1, 12)); h2f = 1'b0; end
            rst_n = ($urandom_range(0, 1499) != 0);
            tick(1);
        end
        rst_n = 1'b1; button_n = 4'hF; h2f = 1'b1;
        tick(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
